mapu_b_arb: RTL and testbench

MAPU_B_ARB -- requirements
Module: mapu_b_arb

---
 rtl/mapu_b_pkg.sv | 21 ++
 rtl/mapu_b_rr_sel.sv | 32 +++
 rtl/mapu_b_arb.sv | 167 ++++++++++++++++
 tb/tb_mapu_b_arb.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapu_b_pkg.sv
// Shared types for the Matrix APU Block arbiter: FSM state encoding, opcode values
// and the round-robin pointer advance helper.
package mapu_b_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FWD_IN  = 2'd1,
      ST_FWD_OUT = 2'd2
   } state_e;

   typedef enum logic {
      OP_ADD  = 1'b0,
      OP_MULT = 1'b1
   } op_e;

   // Pointer moves to the slot just after the finishing owner, wrapping at num.
   function automatic int rr_next(input int idx, input int num);
      return (idx + 1 >= num) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mapu_b_rr_sel.sv
// Round-robin selector: picks the first asserted request at or after ptr, wrapping.
// Purely combinational; produces both a one-hot grant and its index.
module mapu_b_rr_sel #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_vec,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [IDW-1:0]     gnt_idx
);

   logic found;
   int   pos;

   always_comb begin
      found   = 1'b0;
      pos     = 0;
      gnt_oh  = '0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!found && req_vec[pos]) begin
            found       = 1'b1;
            gnt_oh[pos] = 1'b1;
            gnt_idx     = IDW'(pos);
         end
      end
   end

endmodule

// File: rtl/mapu_b_arb.sv
// Arbiter sharing one Matrix APU Block among NUM_REQ requesters: round-robin grant,
// 2*DIM input rows forwarded to the APU, DIM result rows returned to the owner.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no owner; arbitrate among req_i_vld, all handshakes low
//   ST_FWD_IN  | owner's A then B rows passed straight through to the APU
//   ST_FWD_OUT | APU result rows passed straight back to the owner
module mapu_b_arb
   import mapu_b_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DIM        = 3,
   localparam int ROW_W     = DIM * DATA_WIDTH,
   localparam int IDW       = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset_n,

   input  logic [NUM_REQ-1:0]         req_i_vld,
   output logic [NUM_REQ-1:0]         req_i_rdy,
   input  logic [NUM_REQ-1:0]         req_i_op,
   input  logic [NUM_REQ*ROW_W-1:0]   req_i_r,

   output logic [NUM_REQ-1:0]         req_o_vld,
   input  logic [NUM_REQ-1:0]         req_o_rdy,
   output logic [ROW_W-1:0]           req_o_r,
   output logic                       req_o_ovf,

   output logic                       apu_i_vld,
   input  logic                       apu_i_rdy,
   output logic                       apu_i_op,
   output logic [ROW_W-1:0]           apu_i_r,

   input  logic                       apu_o_vld,
   output logic                       apu_o_rdy,
   input  logic [ROW_W-1:0]           apu_o_r,
   input  logic                       apu_o_ovf,

   output logic                       busy,
   output logic [IDW-1:0]             gnt_id
);

   localparam int CNT_W = $clog2(2 * DIM + 1);
   localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(2 * DIM - 1);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(DIM - 1);

   state_e            state_q,   state_d;
   logic [IDW-1:0]    owner_q,   owner_d;
   logic [IDW-1:0]    ptr_q,     ptr_d;
   logic [CNT_W-1:0]  in_cnt_q,  in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   op_e               op_q,      op_d;

   logic [NUM_REQ-1:0] sel_gnt;
   logic [IDW-1:0]     sel_idx;
   logic               sel_any;
   logic               in_fire;
   logic               out_fire;

   mapu_b_rr_sel #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_sel (
      .req_vec (req_i_vld),
      .ptr     (ptr_q),
      .gnt_oh  (sel_gnt),
      .gnt_idx (sel_idx)
   );

   assign sel_any  = |sel_gnt;
   assign in_fire  = (state_q == ST_FWD_IN)  && req_i_vld[owner_q] && apu_i_rdy;
   assign out_fire = (state_q == ST_FWD_OUT) && apu_o_vld && req_o_rdy[owner_q];

   // Datapath muxing is combinational so the arbiter adds no latency to either direction.
   always_comb begin
      req_i_rdy = '0;
      req_o_vld = '0;
      req_o_r   = '0;
      req_o_ovf = 1'b0;
      apu_i_vld = 1'b0;
      apu_i_r   = '0;
      apu_i_op  = op_q;
      apu_o_rdy = 1'b0;
      case (state_q)
         ST_FWD_IN: begin
            apu_i_vld          = req_i_vld[owner_q];
            req_i_rdy[owner_q] = apu_i_rdy;
            apu_i_r            = req_i_r[int'(owner_q) * ROW_W +: ROW_W];
            // Before the first beat lands the opcode is still live from the requester.
            if (in_cnt_q == '0) apu_i_op = req_i_op[owner_q];
         end
         ST_FWD_OUT: begin
            req_o_vld[owner_q] = apu_o_vld;
            apu_o_rdy          = req_o_rdy[owner_q];
            req_o_r            = apu_o_r;
            req_o_ovf          = apu_o_ovf;
         end
         default: ;
      endcase
   end

   assign busy   = (state_q != ST_IDLE);
   assign gnt_id = (state_q == ST_IDLE) ? '0 : owner_q;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      op_d      = op_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_any) begin
               owner_d   = sel_idx;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               state_d   = ST_FWD_IN;
            end
         end
         ST_FWD_IN: begin
            if (in_fire) begin
               if (in_cnt_q == '0) op_d = op_e'(req_i_op[owner_q]);
               if (in_cnt_q == IN_LAST) begin
                  in_cnt_d = '0;
                  state_d  = ST_FWD_OUT;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_FWD_OUT: begin
            if (out_fire) begin
               if (out_cnt_q == OUT_LAST) begin
                  out_cnt_d = '0;
                  ptr_d     = IDW'(rr_next(int'(owner_q), NUM_REQ));
                  state_d   = ST_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         op_q      <= OP_ADD;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         op_q      <= op_d;
      end
   end

endmodule

// File: tb/tb_mapu_b_arb.sv
// Self-checking bench for mapu_b_arb: requester/APU agents plus a transaction-level
// model of grant order, forwarded rows and returned results.
module tb_mapu_b_arb;

   localparam int NR        = 4;
   localparam int DW        = 32;
   localparam int DIM       = 3;
   localparam int ROW_W     = DIM * DW;
   localparam int IDW       = 2;
   localparam int IN_BEATS  = 2 * DIM;
   localparam int OUT_BEATS = DIM;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NR-1:0]         req_i_vld;
   logic [NR-1:0]         req_i_rdy;
   logic [NR-1:0]         req_i_op;
   logic [NR*ROW_W-1:0]   req_i_r;
   logic [NR-1:0]         req_o_vld;
   logic [NR-1:0]         req_o_rdy;
   logic [ROW_W-1:0]      req_o_r;
   logic                  req_o_ovf;
   logic                  apu_i_vld;
   logic                  apu_i_rdy;
   logic                  apu_i_op;
   logic [ROW_W-1:0]      apu_i_r;
   logic                  apu_o_vld;
   logic                  apu_o_rdy;
   logic [ROW_W-1:0]      apu_o_r;
   logic                  apu_o_ovf;
   logic                  busy;
   logic [IDW-1:0]        gnt_id;

   mapu_b_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DIM(DIM)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_i_vld (req_i_vld),
      .req_i_rdy (req_i_rdy),
      .req_i_op  (req_i_op),
      .req_i_r   (req_i_r),
      .req_o_vld (req_o_vld),
      .req_o_rdy (req_o_rdy),
      .req_o_r   (req_o_r),
      .req_o_ovf (req_o_ovf),
      .apu_i_vld (apu_i_vld),
      .apu_i_rdy (apu_i_rdy),
      .apu_i_op  (apu_i_op),
      .apu_i_r   (apu_i_r),
      .apu_o_vld (apu_o_vld),
      .apu_o_rdy (apu_o_rdy),
      .apu_o_r   (apu_o_r),
      .apu_o_ovf (apu_o_ovf),
      .busy      (busy),
      .gnt_id    (gnt_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // requester side
   bit   [NR-1:0]    want;
   int               beat_in [NR];
   logic [ROW_W-1:0] rows [NR][IN_BEATS];
   logic             op_k [NR];

   // transaction model: 0 = no owner, 1 = sending rows, 2 = returning results
   int               phase;
   int               owner;
   int               ref_ptr;
   int               apu_in;
   int               res_idx;
   logic [ROW_W-1:0] res [OUT_BEATS];
   logic             res_ovf [OUT_BEATS];
   int               ops_done;

   // agent behaviour knobs
   int               irdy_mode;
   bit               ordy_rand;
   bit               stall;
   bit               early;
   bit               early_rand;

   // observations of the DUT
   int               gnt_log [$];
   bit               dut_busy_prev;
   int               dut_in_beats;
   int               dut_out_beats [NR];

   function automatic logic [ROW_W-1:0] rand_row();
      logic [ROW_W-1:0] r;
      for (int d = 0; d < DIM; d++) r[d*DW +: DW] = $urandom;
      return r;
   endfunction

   function automatic int rr_pick(input logic [NR-1:0] v, input int p);
      for (int i = 0; i < NR; i++) begin
         if (v[(p + i) % NR]) return (p + i) % NR;
      end
      return -1;
   endfunction

   task automatic model_init();
      phase = 0; owner = 0; ref_ptr = 0; apu_in = 0; res_idx = 0; ops_done = 0;
      want = '0;
      for (int k = 0; k < NR; k++) begin
         beat_in[k] = 0; dut_out_beats[k] = 0; op_k[k] = 1'b0;
      end
      gnt_log.delete();
      dut_busy_prev = 1'b0; dut_in_beats = 0;
      irdy_mode = 0; ordy_rand = 1'b0; stall = 1'b0; early = 1'b0; early_rand = 1'b0;
   endtask

   task automatic zero_inputs();
      req_i_vld = '0; req_i_op = '0; req_i_r = '0; req_o_rdy = '0;
      apu_i_rdy = 1'b0; apu_o_vld = 1'b0; apu_o_r = '0; apu_o_ovf = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      zero_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_init();
   endtask

   task automatic arm(input int k, input int op);
      want[k]    = 1'b1;
      beat_in[k] = 0;
      op_k[k]    = (op < 0) ? 1'($urandom) : 1'(op);
      for (int b = 0; b < IN_BEATS; b++) rows[k][b] = rand_row();
   endtask

   // One clock of both agents, the per-cycle comparisons, and the model update.
   task automatic tick();
      logic [NR-1:0]  vld, exp_irdy, exp_ovld;
      logic           exp_aivld, exp_aordy;
      logic [IDW-1:0] exp_gnt;
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
         vld[k] = want[k] && (beat_in[k] < IN_BEATS) && (!stall || $urandom_range(0, 3) != 0);
         req_i_r[k*ROW_W +: ROW_W] = rows[k][(beat_in[k] < IN_BEATS) ? beat_in[k] : 0];
         req_i_op[k] = (beat_in[k] == 0) ? op_k[k] : 1'($urandom);
      end
      req_i_vld = vld;
      case (irdy_mode)
         0:       apu_i_rdy = 1'b1;
         1:       apu_i_rdy = ~apu_i_rdy;
         default: apu_i_rdy = 1'($urandom);
      endcase
      req_o_rdy = ordy_rand ? NR'($urandom) : '1;
      apu_o_vld = (phase != 0) && (res_idx < OUT_BEATS) && (early || apu_in == IN_BEATS);
      apu_o_r   = res[(res_idx < OUT_BEATS) ? res_idx : 0];
      apu_o_ovf = res_ovf[(res_idx < OUT_BEATS) ? res_idx : 0];
      #1;
      exp_gnt   = (phase != 0) ? IDW'(owner) : '0;
      exp_irdy  = '0; exp_ovld = '0; exp_aivld = 1'b0; exp_aordy = 1'b0;
      if (phase == 1) begin
         exp_aivld       = vld[owner];
         exp_irdy[owner] = apu_i_rdy;
      end
      if (phase == 2) begin
         exp_ovld[owner] = apu_o_vld;
         exp_aordy       = req_o_rdy[owner];
      end
      checks++;
      if (busy !== (phase != 0) || gnt_id !== exp_gnt) begin
         errors++;
         $display("FAIL ctrl t=%0t busy/gnt got %b/%0d want %b/%0d", $time, busy, gnt_id, phase != 0, exp_gnt);
      end
      checks++;
      if ({req_i_rdy, apu_i_vld, apu_o_rdy, req_o_vld} !== {exp_irdy, exp_aivld, exp_aordy, exp_ovld}) begin
         errors++;
         $display("FAIL handshake t=%0t irdy/aivld/aordy/ovld got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                  req_i_rdy, apu_i_vld, apu_o_rdy, req_o_vld, exp_irdy, exp_aivld, exp_aordy, exp_ovld);
      end
      if (exp_aivld) begin
         checks++;
         if (apu_i_r !== rows[owner][beat_in[owner]] || apu_i_op !== op_k[owner]) begin
            errors++;
            $display("FAIL fwd_in t=%0t beat %0d row/op got %h/%b want %h/%b", $time, beat_in[owner],
                     apu_i_r, apu_i_op, rows[owner][beat_in[owner]], op_k[owner]);
         end
      end
      if (phase == 2 && apu_o_vld) begin
         checks++;
         if (req_o_r !== res[res_idx] || req_o_ovf !== res_ovf[res_idx]) begin
            errors++;
            $display("FAIL fwd_out t=%0t beat %0d row/ovf got %h/%b want %h/%b", $time, res_idx,
                     req_o_r, req_o_ovf, res[res_idx], res_ovf[res_idx]);
         end
      end
      // DUT-side observations
      if (busy === 1'b1 && !dut_busy_prev) gnt_log.push_back(int'(gnt_id));
      dut_busy_prev = (busy === 1'b1);
      if (apu_i_vld === 1'b1 && apu_i_rdy) dut_in_beats++;
      for (int k = 0; k < NR; k++) if (req_o_vld[k] === 1'b1 && req_o_rdy[k]) dut_out_beats[k]++;
      // model advance at the coming rising edge
      case (phase)
         0: if (vld != '0) begin
               owner   = rr_pick(vld, ref_ptr);
               phase   = 1;
               apu_in  = 0;
               res_idx = 0;
               if (early_rand) early = 1'($urandom);
               for (int j = 0; j < OUT_BEATS; j++) begin
                  res[j] = rand_row(); res_ovf[j] = 1'($urandom);
               end
            end
         1: if (vld[owner] && apu_i_rdy) begin
               beat_in[owner]++;
               apu_in++;
               if (apu_in == IN_BEATS) phase = 2;
            end
         default: if (apu_o_vld && req_o_rdy[owner]) begin
               res_idx++;
               if (res_idx == OUT_BEATS) begin
                  phase       = 0;
                  ref_ptr     = (owner + 1) % NR;
                  want[owner] = 1'b0;
                  ops_done++;
               end
            end
      endcase
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n = 0;
      while ((want != '0 || phase != 0) && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (want != '0 || phase != 0) begin
         errors++;
         $display("FAIL timeout after %0d cycles pending %b phase %0d", n, want, phase);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req_i_vld = '1; req_i_op = '1; req_i_r = {NR{rand_row()}}; req_o_rdy = '1;
      apu_i_rdy = 1'b1; apu_o_vld = 1'b1; apu_o_r = rand_row(); apu_o_ovf = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, gnt_id, req_i_rdy, req_o_vld, req_o_r, req_o_ovf, apu_i_vld, apu_i_op, apu_i_r, apu_o_rdy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy %b gnt %0d irdy %b ovld %b aivld %b aordy %b op %b want all 0",
                  busy, gnt_id, req_i_rdy, req_o_vld, apu_i_vld, apu_o_rdy, apu_i_op);
      end
      @(negedge clk);
      zero_inputs();
      reset_n = 1'b1;
      model_init();
      repeat (3) tick();
   endtask

   task automatic test_single_mult();
      apply_reset();
      arm(0, 1);
      run_until_idle(100);
      @(posedge clk); #1;
      checks++;
      if (dut_in_beats != IN_BEATS || dut_out_beats[0] != OUT_BEATS || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_mult in/out/busy got %0d/%0d/%b want %0d/%0d/0",
                  dut_in_beats, dut_out_beats[0], busy, IN_BEATS, OUT_BEATS);
      end
      gnt_log.delete();
      arm(0, -1);
      arm(1, -1);
      run_until_idle(200);
      checks++;
      if (gnt_log.size() < 1 || gnt_log[0] != 1) begin
         errors++;
         $display("FAIL single_ptr first grant got %0d (log size %0d) want 1",
                  (gnt_log.size() > 0) ? gnt_log[0] : -1, gnt_log.size());
      end
   endtask

   task automatic test_all_four();
      int exp_ord [5] = '{0, 1, 2, 3, 0};
      int n = 0;
      apply_reset();
      for (int k = 0; k < NR; k++) arm(k, -1);
      while (gnt_log.size() < 4 && n < 300) begin tick(); n++; end
      arm(0, -1);
      run_until_idle(300);
      checks++;
      if (gnt_log.size() != 5) begin
         errors++;
         $display("FAIL all_four grant count got %0d want 5", gnt_log.size());
      end
      for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
         checks++;
         if (gnt_log[i] != exp_ord[i]) begin
            errors++;
            $display("FAIL all_four grant %0d got %0d want %0d", i, gnt_log[i], exp_ord[i]);
         end
      end
   endtask

   task automatic test_skip();
      apply_reset();
      arm(2, -1);
      run_until_idle(100);
      gnt_log.delete();
      arm(1, -1);
      arm(3, -1);
      run_until_idle(200);
      checks++;
      if (gnt_log.size() != 2 || gnt_log[0] != 3 || gnt_log[1] != 1) begin
         errors++;
         $display("FAIL skip order got %0d,%0d (n=%0d) want 3,1",
                  (gnt_log.size() > 0) ? gnt_log[0] : -1, (gnt_log.size() > 1) ? gnt_log[1] : -1, gnt_log.size());
      end
   endtask

   task automatic test_back_to_back_rdy_toggle();
      apply_reset();
      irdy_mode = 1;
      apu_i_rdy = 1'b0;
      arm(3, 1);
      run_until_idle(100);
      checks++;
      if (dut_in_beats != IN_BEATS || dut_out_beats[3] != OUT_BEATS) begin
         errors++;
         $display("FAIL rdy_toggle in/out beats got %0d/%0d want %0d/%0d",
                  dut_in_beats, dut_out_beats[3], IN_BEATS, OUT_BEATS);
      end
   endtask

   task automatic test_early_out();
      apply_reset();
      early = 1'b1;
      arm(1, 0);
      arm(2, 1);
      run_until_idle(200);
      checks++;
      if (dut_out_beats[1] != OUT_BEATS || dut_out_beats[2] != OUT_BEATS) begin
         errors++;
         $display("FAIL early_out result beats got %0d/%0d want %0d/%0d",
                  dut_out_beats[1], dut_out_beats[2], OUT_BEATS, OUT_BEATS);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      apply_reset();
      arm(1, -1);
      run_until_idle(100);
      arm(2, 1);
      while (beat_in[2] < 3 && n < 50) begin tick(); n++; end
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, gnt_id, req_i_rdy, req_o_vld, req_o_r, req_o_ovf, apu_i_vld, apu_i_op, apu_i_r, apu_o_rdy} !== '0) begin
         errors++;
         $display("FAIL mid_reset outputs got busy %b gnt %0d irdy %b aivld %b aordy %b op %b want all 0",
                  busy, gnt_id, req_i_rdy, apu_i_vld, apu_o_rdy, apu_i_op);
      end
      zero_inputs();
      reset_n = 1'b1;
      model_init();
      arm(1, -1);
      arm(2, -1);
      run_until_idle(200);
      checks++;
      if (gnt_log.size() < 1 || gnt_log[0] != 1) begin
         errors++;
         $display("FAIL mid_reset first grant got %0d want 1", (gnt_log.size() > 0) ? gnt_log[0] : -1);
      end
   endtask

   task automatic test_random();
      int total = 0;
      apply_reset();
      stall = 1'b1; irdy_mode = 2; ordy_rand = 1'b1; early_rand = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < NR; k++) if (!want[k] && $urandom_range(0, 15) == 0) arm(k, -1);
         tick();
      end
      run_until_idle(600);
      for (int k = 0; k < NR; k++) total += dut_out_beats[k];
      checks++;
      if (ops_done == 0 || total != OUT_BEATS * ops_done) begin
         errors++;
         $display("FAIL random result beats got %0d want %0d (ops %0d)", total, OUT_BEATS * ops_done, ops_done);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      zero_inputs();
      model_init();
      test_reset();
      test_all_four();
      test_single_mult();
      test_skip();
      test_back_to_back_rdy_toggle();
      test_early_out();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
